// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter that shares one combinational single-precision adder/subtractor
// among NUM_REQ requesters, with a one-entry result register. Optional statistics: FPU_ARB_STATS_EN.
module fpu_addsub_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 32,
  parameter int CNT_W     = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0]             i_req_add_sub,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_32_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_32_b,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     o_rsp_id,
  output logic [SIZE_DATA-1:0]           o_rsp_32_s,
  output logic [CNT_W-1:0]               o_op_cnt,
  output logic [CNT_W-1:0]               o_stall_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_r;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [ID_W-1:0]      grant_idx_s;
  logic [ID_W-1:0]      next_ptr_s;
  logic [ID_W:0]        cand_s;
  logic                 grant_found_s;
  logic                 can_accept_s;
  logic                 transfer_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic                 fpu_op_s;
  logic [SIZE_DATA-1:0] fpu_a_s;
  logic [SIZE_DATA-1:0] fpu_b_s;
  logic [SIZE_DATA-1:0] fpu_s_s;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    cand_s        = {(ID_W+1){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && i_req_valid[cand_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Handshake and datapath selection for the granted requester.
  always_comb begin
    if (grant_found_s) begin
      grant_s = NUM_REQ'(1) << grant_idx_s;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = grant_idx_s + ID_W'(1);
    end
    can_accept_s = (state_r == EMPTY) || i_rsp_ready;
    transfer_s   = grant_found_s && can_accept_s && !i_rst;
    o_req_ready  = grant_s & {NUM_REQ{can_accept_s && !i_rst}};
    fpu_op_s     = i_req_add_sub[grant_idx_s];
    fpu_a_s      = i_req_32_a[grant_idx_s*SIZE_DATA +: SIZE_DATA];
    fpu_b_s      = i_req_32_b[grant_idx_s*SIZE_DATA +: SIZE_DATA];
  end

  FPU_add_sub #(
    .NUM_OP    (1),
    .SIZE_DATA (SIZE_DATA)
  ) u_fpu (
    .i_add_sub (fpu_op_s),
    .i_a       (fpu_a_s),
    .i_b       (fpu_b_s),
    .o_s       (fpu_s_s)
  );

  // Result-register FSM; a refill while draining keeps the register FULL with no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= EMPTY;
      rr_ptr_r    <= {ID_W{1'b0}};
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= {ID_W{1'b0}};
      o_rsp_32_s  <= {SIZE_DATA{1'b0}};
    end else begin
      if (transfer_s) begin
        rr_ptr_r   <= next_ptr_s;
        o_rsp_id   <= grant_idx_s;
        o_rsp_32_s <= fpu_s_s;
      end
      case (state_r)
        EMPTY: begin
          if (transfer_s) begin
            state_r     <= FULL;
            o_rsp_valid <= 1'b1;
          end
        end
        FULL: begin
          if (i_rsp_ready && !transfer_s) begin
            state_r     <= EMPTY;
            o_rsp_valid <= 1'b0;
          end
        end
        default: begin
          state_r     <= EMPTY;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [CNT_W-1:0] op_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Accepted-operation and stalled-request counters, wrapping naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_cnt_r    <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (transfer_s) begin
        op_cnt_r <= op_cnt_r + CNT_W'(1);
      end
      if ((|i_req_valid) && !transfer_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  assign o_op_cnt    = op_cnt_r;
  assign o_stall_cnt = stall_cnt_r;
`else
  assign o_op_cnt    = {CNT_W{1'b0}};
  assign o_stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// Combinational IEEE-754 single-precision add/subtract, NUM_OP independent lanes,
// round-to-nearest-even, subnormals supported, any NaN input yields the canonical quiet NaN.
module FPU_add_sub #(
  parameter int NUM_OP    = 1,
  parameter int SIZE_DATA = 32
) (
  input  logic [NUM_OP-1:0]           i_add_sub,
  input  logic [NUM_OP*SIZE_DATA-1:0] i_a,
  input  logic [NUM_OP*SIZE_DATA-1:0] i_b,
  output logic [NUM_OP*SIZE_DATA-1:0] o_s
);

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, x, y;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, mys, norm;
    logic [27:0] sum;
    logic [9:0]  e, sh;
    logic [4:0]  lz;
    logic [24:0] m;
    logic        found, up;
    logic        a_nan, b_nan, a_inf, b_inf;
    res = 32'h7FC0_0000;
    x = a; y = b; ex = 8'h00; ey = 8'h00; d = 8'h00;
    mx = 27'h0; my = 27'h0; mys = 27'h0; norm = 27'h0; sum = 28'h0;
    e = 10'h0; sh = 10'h0; lz = 5'h0; m = 25'h0; found = 1'b0; up = 1'b0;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    if (a_nan || b_nan) begin
      res = 32'h7FC0_0000;
    end else if (a_inf && b_inf) begin
      res = (a[31] == b[31]) ? a : 32'h7FC0_0000;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else begin
      // x is the larger magnitude, so the alignment shift and the difference are non-negative.
      if (a[30:0] >= b[30:0]) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      ex = (x[30:23] == 8'h00) ? 8'h01 : x[30:23];
      ey = (y[30:23] == 8'h00) ? 8'h01 : y[30:23];
      mx = {(x[30:23] != 8'h00), x[22:0], 3'b000};
      my = {(y[30:23] != 8'h00), y[22:0], 3'b000};
      d  = ex - ey;
      if (d >= 8'd27) begin
        mys = {26'h0, |my};
      end else begin
        mys = (my >> d) | {26'h0, |(my & ((27'h1 << d) - 27'h1))};
      end
      e = {2'b00, ex};
      if (x[31] == y[31]) begin
        sum = {1'b0, mx} + {1'b0, mys};
        if (sum[27]) begin
          norm = {sum[27:2], sum[1] | sum[0]};
          e    = e + 10'd1;
        end else begin
          norm = sum[26:0];
        end
      end else begin
        sum  = {1'b0, mx} - {1'b0, mys};
        norm = sum[26:0];
        for (int i = 26; i >= 0; i--) begin
          if (!found) begin
            if (norm[i]) begin
              found = 1'b1;
            end else begin
              lz = lz + 5'd1;
            end
          end else begin
            found = found;
          end
        end
        // Normalisation stops at the minimum exponent, leaving a subnormal.
        sh   = ((e - 10'd1) < {5'b00000, lz}) ? (e - 10'd1) : {5'b00000, lz};
        norm = norm << sh;
        e    = e - sh;
      end
      up = norm[2] && (norm[1] || norm[0] || norm[3]);
      m  = {1'b0, norm[26:3]} + {24'h0, up};
      if (m[24]) begin
        m = m >> 1;
        e = e + 10'd1;
      end else begin
        m = m;
      end
      if ((norm == 27'h0) && (x[31] != y[31])) begin
        res = 32'h0000_0000;
      end else if (e >= 10'd255) begin
        res = {x[31], 8'hFF, 23'h0};
      end else begin
        res = {x[31], (m[23] ? e[7:0] : 8'h00), m[22:0]};
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_OP; g++) begin : g_lane
    logic [31:0] b_eff;
    assign b_eff = {i_b[g*SIZE_DATA+31] ^ i_add_sub[g], i_b[g*SIZE_DATA +: 31]};
    assign o_s[g*SIZE_DATA +: SIZE_DATA] = fp_add(i_a[g*SIZE_DATA +: SIZE_DATA], b_eff);
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed table-driven bench for fpu_addsub_arbiter plus hand sequences for
// round-robin, backpressure, special values and reset while FULL.
module tb_fpu_addsub_arbiter;

  localparam int N = 4;
`ifdef FPU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    i_req_add_sub;
  logic [N*32-1:0] i_req_32_a;
  logic [N*32-1:0] i_req_32_b;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [1:0]      o_rsp_id;
  logic [31:0]     o_rsp_32_s;
  logic [15:0]     o_op_cnt;
  logic [15:0]     o_stall_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.NUM_REQ(N), .SIZE_DATA(32), .CNT_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_add_sub (i_req_add_sub),
    .i_req_32_a    (i_req_32_a),
    .i_req_32_b    (i_req_32_b),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_32_s    (o_rsp_32_s),
    .o_op_cnt      (o_op_cnt),
    .o_stall_cnt   (o_stall_cnt)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [31:0] exp_s;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] exp_rr [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [31:0] a, input logic [31:0] b);
    i_req_32_a = {N{a}};
    i_req_32_b = {N{b}};
  endtask

  // One clock: drive at negedge, check combinational ready, then wait past the rising edge.
  task automatic cyc(input logic [3:0] v, input logic [3:0] sub, input logic rdy,
                     input logic rst_v, input logic [3:0] exp_ready, input string tag);
    @(negedge clk);
    i_rst         = rst_v;
    i_req_valid   = v;
    i_req_add_sub = sub;
    i_rsp_ready   = rdy;
    #1;
    check(tag, 32'(o_req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id, input logic [31:0] s);
    check({tag, "_valid"}, 32'(o_rsp_valid), 32'(v));
    check({tag, "_id"}, 32'(o_rsp_id), 32'(id));
    check({tag, "_data"}, o_rsp_32_s, s);
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 4'b0000, 32'h3FC00000, 32'h40100000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h40700000};
    tbl[1]  = '{4'b0100, 4'b0100, 32'h40A00000, 32'h40400000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h40000000};
    tbl[2]  = '{4'b1000, 4'b0000, 32'h3F800000, 32'h3F800000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h40000000};
    tbl[3]  = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};
    tbl[4]  = '{4'b0010, 4'b0010, 32'h3F800000, 32'h40000000, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hBF800000};
    tbl[5]  = '{4'b0010, 4'b0010, 32'h40400000, 32'h3F800000, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hBF800000};
    tbl[6]  = '{4'b0010, 4'b0010, 32'h40400000, 32'h3F800000, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h40000000};
    tbl[7]  = '{4'b0011, 4'b0000, 32'h3F800000, 32'h3F800000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h40000000};
    tbl[8]  = '{4'b0011, 4'b0000, 32'h40000000, 32'h40000000, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h40800000};
    tbl[9]  = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h40800000};
    tbl[10] = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};
    tbl[11] = '{4'b0100, 4'b0100, 32'h3F800001, 32'h3F800000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h34000000};
    tbl[12] = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};
    tbl[13] = '{4'b0001, 4'b0000, 32'h3F800000, 32'h33800000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h3F800000};
    tbl[14] = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};
    exp_rr[0] = 32'h40000000;
    exp_rr[1] = 32'h40400000;
    exp_rr[2] = 32'h40800000;
    exp_rr[3] = 32'h40A00000;

    i_rst = 1'b1; i_req_valid = 4'b0000; i_req_add_sub = 4'b0000; i_rsp_ready = 1'b0;
    set_lanes(32'h3F800000, 32'h3F800000);

    // Reset state, with requests pending during reset.
    cyc(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, "rst_ready");
    cyc(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, "rst_ready2");
    check_rsp("rst", 1'b0, 2'd0, 32'h0);
    check("rst_op_cnt", 32'(o_op_cnt), 32'h0);
    check("rst_stall_cnt", 32'(o_stall_cnt), 32'h0);

    for (int r = 0; r < 15; r++) begin
      set_lanes(tbl[r].a, tbl[r].b);
      cyc(tbl[r].valid, tbl[r].sub, tbl[r].rdy, 1'b0, tbl[r].exp_ready, $sformatf("tbl%0d_ready", r));
      check($sformatf("tbl%0d_valid", r), 32'(o_rsp_valid), 32'(tbl[r].exp_valid));
      if (tbl[r].exp_valid) begin
        check($sformatf("tbl%0d_id", r), 32'(o_rsp_id), 32'(tbl[r].exp_id));
        check($sformatf("tbl%0d_data", r), o_rsp_32_s, tbl[r].exp_s);
      end
    end
    check("tbl_op_cnt", 32'(o_op_cnt), STATS ? 32'd9 : 32'd0);
    check("tbl_stall_cnt", 32'(o_stall_cnt), STATS ? 32'd1 : 32'd0);

    // Round robin with distinct operands per requester: (k+1) + 1.0.
    cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, "rr_rst");
    i_req_32_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    i_req_32_b = {N{32'h3F800000}};
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 4'b0000, 1'b1, 1'b0, 4'(1 << (k % 4)), $sformatf("rr%0d_ready", k));
      check_rsp($sformatf("rr%0d", k), 1'b1, 2'(k % 4), exp_rr[k % 4]);
    end
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "rr_drain");
    check("rr_op_cnt", 32'(o_op_cnt), STATS ? 32'd5 : 32'd0);
    check("rr_stall_cnt", 32'(o_stall_cnt), 32'd0);

    // Backpressure: result held while the consumer stalls, new operands waiting.
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, "bp_rst");
    set_lanes(32'h3F800000, 32'h3F800000);
    cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, "bp_first_ready");
    check_rsp("bp_first", 1'b1, 2'd1, 32'h40000000);
    set_lanes(32'h40000000, 32'h40000000);
    for (int s = 0; s < 3; s++) begin
      cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, $sformatf("bp_stall%0d_ready", s));
      check_rsp($sformatf("bp_stall%0d", s), 1'b1, 2'd1, 32'h40000000);
    end
    check("bp_stall_cnt", 32'(o_stall_cnt), STATS ? 32'd3 : 32'd0);
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, "bp_release_ready");
    check_rsp("bp_release", 1'b1, 2'd1, 32'h40800000);
    check("bp_op_cnt", 32'(o_op_cnt), STATS ? 32'd2 : 32'd0);

    // Infinity minus infinity gives NaN; then reset while FULL with rr_ptr advanced.
    cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, "sp_rst");
    set_lanes(32'h7F800000, 32'hFF800000);
    cyc(4'b1000, 4'b0000, 1'b1, 1'b0, 4'b1000, "nan_ready");
    check("nan_valid", 32'(o_rsp_valid), 32'h1);
    check("nan_id", 32'(o_rsp_id), 32'd3);
    check("nan_exp", 32'(o_rsp_32_s[30:23]), 32'hFF);
    check("nan_mant_nonzero", 32'(o_rsp_32_s[22:0] != 23'h0), 32'h1);
    set_lanes(32'h3F800000, 32'h3F800000);
    cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, "pre_rst_ready");
    check_rsp("pre_rst", 1'b1, 2'd0, 32'h40000000);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000, "full_rst_ready");
    check_rsp("full_rst", 1'b0, 2'd0, 32'h0);
    check("full_rst_op_cnt", 32'(o_op_cnt), 32'h0);
    check("full_rst_stall_cnt", 32'(o_stall_cnt), 32'h0);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, "post_rst_ready");
    check_rsp("post_rst", 1'b1, 2'd0, 32'h40000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
